// File: rtl/div23_reconstruct.sv
// Rebuilds x = q*D + r from a quotient/remainder pair with an MSB-first Horner multiply-add.
// Optional remainder range check enabled by defining RECON_RANGE_CHECK_EN.
module div23_reconstruct #(
   parameter int unsigned W     = 32,
   parameter int unsigned D     = 23,
   parameter int unsigned QW    = 28,
   parameter int unsigned RW    = 5,
   parameter int unsigned DIGIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [QW-1:0] in_q,
   input  logic [RW-1:0] in_r,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_x,
   output logic          out_ovf,
   output logic          out_err
);

   localparam int unsigned NDIG = QW / DIGIT;
   localparam int unsigned AW   = W + DIGIT + RW + 1;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   if (QW % DIGIT != 0) begin : g_bad_digit
      $error("div23_reconstruct: QW must be a multiple of DIGIT");
   end
   if (D >= (64'd1 << RW)) begin : g_bad_divisor
      $error("div23_reconstruct: D must fit in RW bits");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [QW-1:0]   q_q, q_d;
   logic [RW-1:0]   r_q, r_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    out_x_q, out_x_d;
   logic            out_ovf_q, out_ovf_d;
   logic            out_err_q, out_err_d;

   logic [DIGIT-1:0] digit;
   logic [AW-1:0]    sum;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         q_q         <= '0;
         r_q         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_ovf_q   <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         q_q         <= q_d;
         r_q         <= r_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_ovf_q   <= out_ovf_d;
         out_err_q   <= out_err_d;
      end
   end

   // The latched quotient shifts left each RUN cycle, so the current digit is always on top
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      q_d       = q_q;
      r_d       = r_q;
      out_x_d   = out_x_q;
      out_ovf_d = out_ovf_q;
      out_err_d = out_err_q;
      digit     = q_q[QW-1 -: DIGIT];
      sum       = acc_q + AW'(r_q);

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               q_d     = in_q;
               r_d     = in_r;
               acc_d   = '0;
               cnt_d   = CW'(NDIG - 1);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = (acc_q << DIGIT) + AW'(digit) * AW'(D);
            q_d   = q_q << DIGIT;
            if (cnt_q == '0) begin
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_FIN: begin
            out_x_d   = sum[W-1:0];
            out_ovf_d = |sum[AW-1:W];
`ifdef RECON_RANGE_CHECK_EN
            out_err_d = (r_q >= RW'(D));
`else
            out_err_d = 1'b0;
`endif
            state_d   = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_x     = out_x_q;
   assign out_ovf   = out_ovf_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_div23_reconstruct.sv
// Scoreboard bench for div23_reconstruct: directed vectors, stall, mid-run reset and a random sweep.
module tb_div23_reconstruct;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [27:0] in_q;
   logic [4:0]  in_r;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_x;
   logic        out_ovf;
   logic        out_err;

   div23_reconstruct dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_q      (in_q),
      .in_r      (in_r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_ovf   (out_ovf),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic        ovf;
      logic        err;
      longint      acc_cyc;
   } exp_t;

   exp_t   sb[$];
   int     tests = 0;
   int     fails = 0;
   longint cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: latency on rising out_valid, stability while stalled, values on handshake
   logic        prev_valid = 1'b0;
   logic [31:0] hold_x;
   logic        hold_ovf, hold_err;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", 64'(out_valid), 64'd0);
            end else begin
               chk("latency", 64'(cyc - sb[0].acc_cyc), 64'd8);
               hold_x   = out_x;
               hold_ovf = out_ovf;
               hold_err = out_err;
            end
         end else if (out_valid) begin
            chk("stable_x", 64'(out_x), 64'(hold_x));
            chk("stable_ovf", 64'(out_ovf), 64'(hold_ovf));
            chk("stable_err", 64'(out_err), 64'(hold_err));
         end
         if (out_valid && out_ready && sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("out_x", 64'(out_x), 64'(mon_e.x));
            chk("out_ovf", 64'(out_ovf), 64'(mon_e.ovf));
            chk("out_err", 64'(out_err), 64'(mon_e.err));
         end
         prev_valid = out_valid;
      end
   end

   task automatic send(input logic [27:0] q, input logic [4:0] r,
                       input logic [31:0] x, input logic ovf);
      exp_t e;
      int   n = 0;
      in_q     = q;
      in_r     = r;
      in_valid = 1'b1;
      while (!in_ready && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      e.x   = x;
      e.ovf = ovf;
`ifdef RECON_RANGE_CHECK_EN
      e.err = (r >= 5'd23);
`else
      e.err = 1'b0;
`endif
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_q     = q ^ 28'hA5C3E1F;
      in_r     = ~r;
   endtask

   task automatic send_model(input logic [27:0] q, input logic [4:0] r);
      longint full;
      full = longint'(q) * 23 + longint'(r);
      send(q, r, full[31:0], |full[63:32]);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   localparam int NV = 8;
   logic [27:0] tq [NV] = '{28'h0, 28'h5, 28'hB21642C, 28'hB21642C, 28'h10, 28'hFFFFFFF, 28'h1000000, 28'h1};
   logic [4:0]  tr [NV] = '{5'd0, 5'd3, 5'd11, 5'd12, 5'd23, 5'd31, 5'd22, 5'd0};
   logic [31:0] tx [NV] = '{32'h0, 32'd118, 32'hFFFFFFFF, 32'h0, 32'd391, 32'h70000008, 32'h17000016, 32'd23};
   logic        tv [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_q      = '0;
      in_r      = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_x", 64'(out_x), 64'd0);
      chk("rst_out_ovf", 64'(out_ovf), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);

      for (int i = 0; i < NV; i++) send(tq[i], tr[i], tx[i], tv[i]);
      drain();

      // Stall in DONE with a second pair waiting
      out_ready = 1'b0;
      send(28'h5, 5'd3, 32'd118, 1'b0);
      in_q     = 28'h10;
      in_r     = 5'd7;
      in_valid = 1'b1;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("stall_valid_seen", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_out_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      send(28'h10, 5'd7, 32'd375, 1'b0);
      drain();

      // Reset during RUN discards the result
      send(28'hB21642C, 5'd11, 32'hFFFFFFFF, 1'b0);
      drain();
      send(28'h5, 5'd3, 32'd118, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_x", 64'(out_x), 64'd0);
      chk("midrst_out_ovf", 64'(out_ovf), 64'd0);
      chk("midrst_out_err", 64'(out_err), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("postrst_no_valid", 64'(out_valid), 64'd0);
      end
      chk("postrst_in_ready", 64'(in_ready), 64'd1);
      send(28'h5, 5'd3, 32'd118, 1'b0);
      drain();

      // Random sweep against the arithmetic model
      for (int i = 0; i < 300; i++) begin
         send_model(28'($urandom()), 5'($urandom_range(0, 31)));
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
